mem_stage_ls: RTL and testbench

Parametrised MEM stage for the pipelined MIPS core, successor to the current word-only data-memory stage. It combines a byte-addressable data RAM with byte/half/word stores and loads, sign/zero extension, and the MemToReg select. A MEM/WB pipeline register supports stall, flush and valid tracking. It sits between the EX/MEM buffer and the register-file write-back.

---
 rtl/mem_stage_pkg.sv | 24 ++
 rtl/mem_stage_ls_load_align.sv | 29 ++
 rtl/mem_stage_ls.sv | 121 ++++++++++++
 tb/tb_mem_stage_ls.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared constants and helpers for the MEM stage: access-size codes, lane
// count and the store byte-enable generator.
package mem_stage_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int LANES = 4;

    // Byte enables for a store; half uses only addr_lo[1] and word uses
    // neither bit, so a misaligned address is naturally force-aligned.
    function automatic logic [LANES-1:0] byte_enable(input logic [1:0] size,
                                                     input logic [1:0] addr_lo);
        logic [LANES-1:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << addr_lo;
            SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;  // word, and reserved 2'b11 treated as word
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_stage_ls_load_align.sv
// Load alignment: picks the addressed byte or half out of a little-endian
// RAM word and sign- or zero-extends it; word loads pass straight through.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane select followed by extension according to access size.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        o_data = i_word;
        w_byte = i_word[8*i_addr_lo +: 8];
        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
        case (i_size)
            SZ_BYTE: o_data = i_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            SZ_HALF: o_data = i_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/mem_stage_ls.sv
// MEM stage: byte-addressable data RAM with byte/half/word stores and loads,
// MemToReg select and a MEM/WB register with flush > stall > load priority.
// Optional macro MEM_STAGE_MISALIGN_TRAP_EN: detect misaligned half/word
// accesses, suppress the store and write-back, and flag them on misalign_o.
// Without it, half/word addresses are force-aligned and misalign_o stays 0.
module mem_stage_ls
    import mem_stage_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int REG_ADDR_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    input  logic [DATA_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic                  mem_write_i,
    input  logic                  mem_read_i,
    input  logic                  mem_to_reg_i,
    input  logic [1:0]            size_i,
    input  logic                  unsigned_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  logic                  reg_write_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    output logic [DATA_W-1:0]     wb_data_o,
    output logic [REG_ADDR_W-1:0] rd_o,
    output logic                  reg_write_o,
    output logic                  valid_o,
    output logic                  misalign_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

    logic [AW-1:0]     w_idx;
    logic [DATA_W-1:0] w_raw;
    logic [DATA_W-1:0] w_load;
    logic [DATA_W-1:0] w_next_data;
    logic [DATA_W-1:0] w_wdata_rep;
    logic [LANES-1:0]  w_be;
    logic              w_misalign;
    logic              w_wen;

    // Address bits above the RAM window are ignored so addresses wrap.
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = ^addr_i[DATA_W-1:AW+2];

    assign w_idx = addr_i[AW+1:2];
    assign w_raw = r_mem[w_idx];

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    assign w_misalign = (mem_read_i | mem_write_i) &
                        (((size_i == SZ_HALF) & addr_i[0]) |
                         (size_i[1] & (addr_i[1:0] != 2'b00)));
`else
    assign w_misalign = 1'b0;
    logic w_unused_mem_read;
    assign w_unused_mem_read = mem_read_i;
`endif

    assign w_wen = valid_i & mem_write_i & ~stall_i & ~flush_i & ~w_misalign;
    assign w_be  = byte_enable(size_i, addr_i[1:0]);

    load_align u_load_align (
        .i_word     (w_raw),
        .i_addr_lo  (addr_i[1:0]),
        .i_size     (size_i),
        .i_unsigned (unsigned_i),
        .o_data     (w_load)
    );

    assign w_next_data = mem_to_reg_i ? w_load : addr_i;

    // Replicate store data across lanes so each enabled lane sees its bytes.
    always_comb begin
        w_wdata_rep = wdata_i;
        case (size_i)
            SZ_BYTE: w_wdata_rep = {4{wdata_i[7:0]}};
            SZ_HALF: w_wdata_rep = {2{wdata_i[15:0]}};
            default: w_wdata_rep = wdata_i;
        endcase
    end

    // MEM/WB pipeline register: flush clears, stall holds, otherwise load.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (!rst_n) begin
            wb_data_o   <= '0;
            rd_o        <= '0;
            reg_write_o <= 1'b0;
            valid_o     <= 1'b0;
            misalign_o  <= 1'b0;
        end else if (flush_i) begin
            wb_data_o   <= '0;
            rd_o        <= '0;
            reg_write_o <= 1'b0;
            valid_o     <= 1'b0;
            misalign_o  <= 1'b0;
        end else if (!stall_i) begin
            wb_data_o   <= w_next_data;
            rd_o        <= rd_i;
            reg_write_o <= reg_write_i & valid_i & ~w_misalign;
            valid_o     <= valid_i;
            misalign_o  <= w_misalign & valid_i;
        end
    end

    // Byte-lane RAM write; the load path reads the pre-edge contents.
    always_ff @(posedge clk) begin
        // NOTE: the RAM array is deliberately not reset; software must initialise it.
        for (int l = 0; l < LANES; l++) begin
            if (w_wen && w_be[l]) begin
                r_mem[w_idx][8*l +: 8] <= w_wdata_rep[8*l +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ls.sv
// Self-checking bench for mem_stage_ls: directed steps from the test plan
// followed by random traffic, all checked against a byte-array model.
module tb_mem_stage_ls;

    localparam int MEM_BYTES = 1024;

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        mem_write_i;
    logic        mem_read_i;
    logic        mem_to_reg_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic [4:0]  rd_i;
    logic        reg_write_i;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] wb_data_o;
    logic [4:0]  rd_o;
    logic        reg_write_o;
    logic        valid_o;
    logic        misalign_o;

    int checks = 0;
    int errors = 0;

    // Reference state: the RAM as plain bytes plus the expected MEM/WB outputs.
    logic [7:0]  mbytes [MEM_BYTES];
    logic [31:0] exp_data;
    logic [4:0]  exp_rd;
    logic        exp_rw;
    logic        exp_v;
    logic        exp_mis;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    mem_stage_ls dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_i      (valid_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .mem_write_i  (mem_write_i),
        .mem_read_i   (mem_read_i),
        .mem_to_reg_i (mem_to_reg_i),
        .size_i       (size_i),
        .unsigned_i   (unsigned_i),
        .rd_i         (rd_i),
        .reg_write_i  (reg_write_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .wb_data_o    (wb_data_o),
        .rd_o         (rd_o),
        .reg_write_o  (reg_write_o),
        .valid_o      (valid_o),
        .misalign_o   (misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout observed no finish required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".data"}, wb_data_o, exp_data);
        check({tag, ".rd"}, {27'h0, rd_o}, {27'h0, exp_rd});
        check({tag, ".rw"}, {31'h0, reg_write_o}, {31'h0, exp_rw});
        check({tag, ".valid"}, {31'h0, valid_o}, {31'h0, exp_v});
        check({tag, ".mis"}, {31'h0, misalign_o}, {31'h0, exp_mis});
    endtask

    // Bytes covered by an access, little-endian, from the addressing rules.
    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic int model_load(input int base, input int n, input logic uns);
        logic [31:0] v;
        v = 0;
        for (int k = 0; k < n; k++) v = v | (32'(mbytes[(base + k) % MEM_BYTES]) << (8 * k));
        if (!uns && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (!uns && n == 2 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    // One pipeline step: drive, predict, clock, compare all outputs.
    task automatic op(input string tag, input logic v, input logic wr, input logic rdq,
                      input logic m2r, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic rw, input logic st, input logic fl);
        int a, n, base;
        logic mis;
        logic [31:0] ld;
        logic [4:0]  rdx;
        rdx = 5'($urandom);
        valid_i = v; mem_write_i = wr; mem_read_i = rdq; mem_to_reg_i = m2r;
        size_i = sz; unsigned_i = uns; addr_i = addr; wdata_i = wd;
        rd_i = rdx; reg_write_i = rw; stall_i = st; flush_i = fl;

        a = int'(addr % MEM_BYTES);
        n = nbytes(sz);
        mis = TRAP && (wr || rdq) && (a % n != 0);
        base = a - (a % n);
        ld = model_load(base, n, uns);
        if (v && wr && !st && !fl && !mis)
            for (int k = 0; k < n; k++) mbytes[base + k] = wd[8*k +: 8];
        if (fl) begin
            exp_data = 0; exp_rd = 0; exp_rw = 0; exp_v = 0; exp_mis = 0;
        end else if (!st) begin
            exp_data = m2r ? ld : addr;
            exp_rd   = rdx;
            exp_rw   = rw && v && !mis;
            exp_v    = v;
            exp_mis  = mis && v;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic sw(input string tag, input logic [31:0] addr, input logic [31:0] d);
        op(tag, 1, 1, 0, 0, 2'd2, 0, addr, d, 0, 0, 0);
    endtask

    task automatic ld_op(input string tag, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr);
        op(tag, 1, 0, 1, 1, sz, uns, addr, 32'h0, 1, 0, 0);
    endtask

    initial begin
        logic [31:0] exp_mis_word;
        rst_n = 1'b0;
        valid_i = 0; addr_i = 0; wdata_i = 0; mem_write_i = 0; mem_read_i = 0;
        mem_to_reg_i = 0; size_i = 0; unsigned_i = 0; rd_i = 0; reg_write_i = 0;
        stall_i = 0; flush_i = 0;
        exp_data = 0; exp_rd = 0; exp_rw = 0; exp_v = 0; exp_mis = 0;
        #3;
        check_all("reset_init");
        #3 rst_n = 1'b1;

        // Initialise the whole RAM so the model is fully known.
        for (int w = 0; w < MEM_BYTES / 4; w++) sw("init", 32'(w * 4), $urandom);

        sw("sw_deadbeef", 32'h10, 32'hDEADBEEF);
        check("valid_after_sw", {31'h0, valid_o}, 32'h1);
        ld_op("lw_10", 2'd2, 0, 32'h10);
        check("lw_10_const", wb_data_o, 32'hDEADBEEF);

        // Asynchronous reset mid-cycle clears outputs without a clock edge.
        valid_i = 0; mem_write_i = 0; mem_read_i = 0;
        #2 rst_n = 1'b0;
        exp_data = 0; exp_rd = 0; exp_rw = 0; exp_v = 0; exp_mis = 0;
        #1 check_all("async_reset");
        #2 rst_n = 1'b1;

        // Byte and half stores merging into a word.
        sw("sw_20", 32'h20, 32'h11223344);
        op("sb_21", 1, 1, 0, 0, 2'd0, 0, 32'h21, 32'h000000AA, 0, 0, 0);
        ld_op("lw_20a", 2'd2, 0, 32'h20);
        check("sb_merge_const", wb_data_o, 32'h1122AA44);
        op("sh_22", 1, 1, 0, 0, 2'd1, 0, 32'h22, 32'h0000BEEF, 0, 0, 0);
        ld_op("lw_20b", 2'd2, 0, 32'h20);
        check("sh_merge_const", wb_data_o, 32'hBEEFAA44);

        // Sign and zero extension.
        sw("sw_30", 32'h30, 32'h000080F0);
        ld_op("lb", 2'd0, 0, 32'h30);  check("lb_const", wb_data_o, 32'hFFFFFFF0);
        ld_op("lbu", 2'd0, 1, 32'h30); check("lbu_const", wb_data_o, 32'h000000F0);
        ld_op("lh", 2'd1, 0, 32'h30);  check("lh_const", wb_data_o, 32'hFFFF80F0);
        ld_op("lhu", 2'd1, 1, 32'h30); check("lhu_const", wb_data_o, 32'h000080F0);
        op("pass", 1, 0, 0, 0, 2'd2, 0, 32'h1234, 32'h0, 1, 0, 0);
        check("pass_const", wb_data_o, 32'h00001234);

        // Stall blocks the store and holds outputs; flush wins over stall.
        sw("sw_40", 32'h40, 32'hCAFEF00D);
        op("stall_sw", 1, 1, 0, 0, 2'd2, 0, 32'h40, 32'h55, 1, 1, 0);
        ld_op("lw_40", 2'd2, 0, 32'h40);
        check("stall_nowrite_const", wb_data_o, 32'hCAFEF00D);
        op("flush_stall", 1, 0, 1, 1, 2'd2, 0, 32'h40, 32'h0, 1, 1, 1);
        check("flush_valid_const", {31'h0, valid_o}, 32'h0);

        // Misaligned word store: trapped, or force-aligned to 0x40.
        sw("sw_42", 32'h42, 32'h99);
        check("mis_flag_const", {31'h0, misalign_o}, {31'h0, TRAP});
        exp_mis_word = TRAP ? 32'hCAFEF00D : 32'h00000099;
        ld_op("lw_40_mis", 2'd2, 0, 32'h40);
        check("mis_word_const", wb_data_o, exp_mis_word);

        // Address wrap and read-during-write returning old data.
        sw("sw_400", 32'h400, 32'h77);
        ld_op("lw_0", 2'd2, 0, 32'h0);
        check("wrap_const", wb_data_o, 32'h77);
        op("rw_same", 1, 1, 1, 1, 2'd2, 0, 32'h0, 32'h88, 1, 0, 0);
        check("old_data_const", wb_data_o, 32'h77);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            op("rand", $urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
               2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, $urandom,
               $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
               $urandom_range(0, 9) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
